// File: rtl/mstage_lsu_pkg.sv
// mstage_lsu_pkg: shared states, func3 codes, response codes and alignment helper for the M stage
package mstage_lsu_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == F3_LH[1:0] && a[0]) || (f3[1:0] == F3_LW[1:0] && a != 2'b00);
  endfunction
endpackage

// File: rtl/mstage_lsu_align.sv
// mstage_lsu_align: load byte-lane extraction/extension and store lane replication/strobes
module mstage_lsu_align
  import mstage_lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_func3,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ldata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);
  logic [31:0] w_sh;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sb;
  logic        w_shw;
  assign w_sh  = i_rdata >> {i_off, 3'b000};
  assign w_b   = w_sh[7:0];
  assign w_h   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign w_sb  = i_func3[1:0] == F3_SB[1:0];
  assign w_shw = i_func3[1:0] == F3_SH[1:0];
  assign o_ldata = i_func3 == F3_LB  ? {{24{w_b[7]}}, w_b} :
                   i_func3 == F3_LH  ? {{16{w_h[15]}}, w_h} :
                   i_func3 == F3_LBU ? {24'd0, w_b} :
                   i_func3 == F3_LHU ? {16'd0, w_h} : i_rdata;
  assign o_wdata = w_sb ? {4{i_wdata[7:0]}} : w_shw ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_wstrb = w_sb ? 4'b0001 << i_off : w_shw ? 4'b0011 << {i_off[1], 1'b0} :
                   i_func3[1:0] == F3_SW[1:0] ? 4'b1111 : 4'b1111;
endmodule

// File: rtl/mstage_lsu.sv
// mstage_lsu: M pipeline stage performing one AXI4-Lite load or store per accepted instruction
module mstage_lsu
  import mstage_lsu_pkg::*;
#(
  parameter int PASS_W = 192
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       addrE,
  input  logic [31:0]       wdataE,
  input  logic              memrdE,
  input  logic              memwrE,
  input  logic [2:0]        func3E,
  input  logic [PASS_W-1:0] passE,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       mdataM,
  output logic              faultM,
  output logic [PASS_W-1:0] passM,
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [31:0]       awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  state_t            r_state, w_next;
  logic [31:0]       r_addr, r_wdata, r_mdata;
  logic [2:0]        r_func3;
  logic [PASS_W-1:0] r_pass;
  logic              r_fault, r_aw_done, r_w_done;
  logic              w_fire, w_mem, w_mis;
  logic [31:0]       w_ldata, w_wdata;
  logic [3:0]        w_wstrb;
  mstage_lsu_align u_align (
    .i_off  (r_addr[1:0]),
    .i_func3(r_func3),
    .i_rdata(rdata),
    .i_wdata(r_wdata),
    .o_ldata(w_ldata),
    .o_wdata(w_wdata),
    .o_wstrb(w_wstrb)
  );
  assign w_fire  = s_valid && r_state == IDLE;
  assign w_mem   = memrdE || memwrE;
  assign w_mis   = misaligned(func3E, addrE[1:0]);
  assign s_ready = r_state == IDLE;
  assign m_valid = r_state == DONE;
  assign mdataM  = r_mdata;
  assign faultM  = r_fault;
  assign passM   = r_pass;
  assign araddr  = r_addr;
  assign arvalid = r_state == RD_ADDR;
  assign rready  = r_state == RD_DATA;
  assign awaddr  = r_addr;
  assign awvalid = r_state == WR_REQ && !r_aw_done;
  assign wvalid  = r_state == WR_REQ && !r_w_done;
  assign wdata   = r_state == WR_REQ ? w_wdata : 32'd0;
  assign wstrb   = r_state == WR_REQ ? w_wstrb : 4'd0;
  assign bready  = r_state == WR_RESP;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !w_fire ? IDLE : (!w_mem || w_mis) ? DONE : memrdE ? RD_ADDR : WR_REQ;
      RD_ADDR: w_next = arready ? RD_DATA : RD_ADDR;
      RD_DATA: w_next = rvalid ? DONE : RD_DATA;
      WR_REQ:  w_next = ((r_aw_done || awready) && (r_w_done || wready)) ? WR_RESP : WR_REQ;
      WR_RESP: w_next = bvalid ? DONE : WR_RESP;
      DONE:    w_next = m_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_func3   <= '0;
      r_pass    <= '0;
      r_mdata   <= '0;
      r_fault   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_fire) begin
        r_addr    <= addrE;
        r_wdata   <= wdataE;
        r_func3   <= func3E;
        r_pass    <= passE;
        r_mdata   <= '0;
        r_fault   <= w_mem && w_mis;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == RD_DATA && rvalid) begin
        r_mdata <= w_ldata;
        r_fault <= rresp != AXI_RESP_OKAY;
      end
      // each write channel retires on its own handshake; the pair may finish in either order
      if (r_state == WR_REQ) begin
        r_aw_done <= r_aw_done || awready;
        r_w_done  <= r_w_done || wready;
      end
      if (r_state == WR_RESP && bvalid) r_fault <= bresp != AXI_RESP_OKAY;
    end
  end
endmodule
